// File: rtl/hpi_pkg.sv
// Shared state encoding and counter sizing for the HPI bus master.
package hpi_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4,
    TURN     = 3'd5
  } hpi_state_e;

  // Width of the shared phase counter: $clog2 of the longest phase, plus one.
  function automatic int hpi_cnt_width(input int setup_cyc, input int strobe_cyc,
                                       input int hold_cyc, input int turn_cyc);
    int m;
    m = setup_cyc;
    if (strobe_cyc > m) m = strobe_cyc;
    if (hold_cyc > m)   m = hold_cyc;
    if (turn_cyc > m)   m = turn_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hpi_reset_stretch.sv
// Holds the OTG chip reset low for RST_CYC cycles after Reset deasserts;
// rst_done is high on the cycle whose closing edge releases it.
module hpi_reset_stretch #(
  parameter int RST_CYC = 16
) (
  input  logic Clk,
  input  logic Reset,
  output logic rst_n_out,
  output logic rst_done
);

  localparam int               CNT_W  = $clog2(RST_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(RST_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_q, rst_n_d;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    else             rst_n_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments here, so every register samples pre-edge values.
    if (Reset) begin
      cnt_q   <= CNT_LD;
      rst_n_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign rst_done  = (cnt_q == '0) && !rst_n_q;

endmodule

// File: rtl/hpi_bus_master.sv
// HPI bus master: accepts one command at a time and runs a programmable
// setup/strobe/hold/turnaround cycle on the OTG pins; also stretches OTG reset.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2,
  parameter int RST_CYC    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_CS_N,
  output logic              OTG_RST_N
);

  localparam int               CNT_W     = hpi_cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit               HAS_TURN  = (TURN_CYC > 0);

  hpi_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oe_q;
  logic              cs_n_q, rd_n_q, wr_n_q;
  logic              rsp_valid_q, rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              busy_q;
  logic              rst_done;
  logic              otg_rst_n;

  hpi_reset_stretch #(
    .RST_CYC (RST_CYC)
  ) u_reset_stretch (
    .Clk       (Clk),
    .Reset     (Reset),
    .rst_n_out (otg_rst_n),
    .rst_done  (rst_done)
  );

  // Outputs are set on the edge that enters each state, so pins line up with state_q.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        RST_HOLD: begin
          if (rst_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            busy_q  <= 1'b1;
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            oe_q    <= cmd_write;
            cs_n_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= STROBE;
            cnt_q   <= STROBE_LD;
            rd_n_q  <= write_q;
            wr_n_q  <= !write_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            cnt_q       <= HOLD_LD;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= write_q;
            if (!write_q) rsp_rdata_q <= OTG_DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q <= 1'b1;
            oe_q   <= 1'b0;
            if (HAS_TURN) begin
              state_q <= TURN;
              cnt_q   <= TURN_LD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= RST_HOLD;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign OTG_DATA  = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign OTG_ADDR  = addr_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RST_N = otg_rst_n;

endmodule
